// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Command encodings, FSM state type and helpers for multicycle_alu.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] CMD_ADD  = 3'b000;
    localparam logic [2:0] CMD_SUB  = 3'b001;
    localparam logic [2:0] CMD_XOR  = 3'b010;
    localparam logic [2:0] CMD_SLT  = 3'b011;
    localparam logic [2:0] CMD_AND  = 3'b100;
    localparam logic [2:0] CMD_NAND = 3'b101;
    localparam logic [2:0] CMD_NOR  = 3'b110;
    localparam logic [2:0] CMD_OR   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    function automatic logic is_arith(input logic [2:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SLT);
    endfunction

    // Subtraction is a + ~b + 1, so the initial carry is the "+1".
    function automatic logic needs_carry_in(input logic [2:0] cmd);
        return (cmd == CMD_SUB) || (cmd == CMD_SLT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_slice.sv
// ============================================================================
// Module : alu_slice
// Brief  : Combinational SLICE-bit ALU slice, time-multiplexed by multicycle_alu.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             carryin,
    input  logic [2:0]       command,
    output logic [SLICE-1:0] sum,
    output logic             carryout,
    output logic             carry_into_msb
);

    logic [SLICE-1:0] b_eff;
    logic [SLICE:0]   full;

    always_comb begin
        b_eff          = (command == CMD_ADD) ? b : ~b;
        full           = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, carryin};
        sum            = '0;
        carryout       = 1'b0;
        carry_into_msb = 1'b0;
        case (command)
            CMD_ADD, CMD_SUB, CMD_SLT: begin
                sum            = full[SLICE-1:0];
                carryout       = full[SLICE];
                // sum_msb = a ^ b ^ cin at the MSB, so cin falls out by XOR.
                carry_into_msb = a[SLICE-1] ^ b_eff[SLICE-1] ^ full[SLICE-1];
            end
            CMD_XOR:  sum = a ^ b;
            CMD_AND:  sum = a & b;
            CMD_NAND: sum = ~(a & b);
            CMD_NOR:  sum = ~(a | b);
            CMD_OR:   sum = a | b;
            default:  sum = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_alu.sv
// ============================================================================
// Module : multicycle_alu
// Brief  : WIDTH-bit ALU reusing one SLICE-bit slice over WIDTH/SLICE cycles.
//          Optional macro ALU_EARLY_DONE_EN: logical ops finish in one edge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       command,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int BASE_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
        $error("multicycle_alu: WIDTH must be a positive multiple of SLICE");
    end

    alu_state_t       state;
    alu_state_t       next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_cmd;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;

    logic [BASE_W-1:0] w_base;
    logic [SLICE-1:0]  w_sum;
    logic              w_co;
    logic              w_cim;
    logic              w_last;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_merged;
    logic [WIDTH-1:0]  w_final;

    assign w_base = BASE_W'(r_idx) * BASE_W'(SLICE);
    assign w_last = (r_idx == LAST_IDX);
    assign w_ovf  = w_cim ^ w_co;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a              (r_a[w_base +: SLICE]),
        .b              (r_b[w_base +: SLICE]),
        .carryin        (r_carry),
        .command        (r_cmd),
        .sum            (w_sum),
        .carryout       (w_co),
        .carry_into_msb (w_cim)
    );

    always_comb begin
        w_merged                   = result;
        w_merged[w_base +: SLICE]  = w_sum;
        w_final                    = w_merged;
        if (r_cmd == CMD_SLT) begin
            // a < b (signed) is sign(a-b) corrected by overflow.
            w_final = WIDTH'(w_sum[SLICE-1] ^ w_ovf);
        end
    end

`ifdef ALU_EARLY_DONE_EN
    function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] cmd,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        case (cmd)
            CMD_XOR:  return x ^ y;
            CMD_AND:  return x & y;
            CMD_NAND: return ~(x & y);
            CMD_NOR:  return ~(x | y);
            CMD_OR:   return x | y;
            default:  return '0;
        endcase
    endfunction
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ALU_EARLY_DONE_EN
                    next_state = is_arith(command) ? RUN : DONE;
`else
                    next_state = RUN;
`endif
                end
            end
            RUN: begin
                if (w_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_cmd    <= CMD_ADD;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_cmd   <= command;
                        r_idx   <= '0;
                        r_carry <= needs_carry_in(command);
`ifdef ALU_EARLY_DONE_EN
                        if (!is_arith(command)) begin
                            result   <= logic_op(command, a, b);
                            carryout <= 1'b0;
                            overflow <= 1'b0;
                            zero     <= (logic_op(command, a, b) == '0);
                        end
`endif
                    end
                end
                RUN: begin
                    r_carry <= w_co;
                    if (w_last) begin
                        r_idx    <= '0;
                        result   <= w_final;
                        carryout <= ((r_cmd == CMD_ADD) || (r_cmd == CMD_SUB)) ? w_co : 1'b0;
                        overflow <= ((r_cmd == CMD_ADD) || (r_cmd == CMD_SUB)) ? w_ovf : 1'b0;
                        zero     <= (w_final == '0);
                    end else begin
                        r_idx                   <= r_idx + 1'b1;
                        result[w_base +: SLICE] <= w_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
